mbm_pipe_mul: RTL and testbench
===============================

// Module: mbm_pipe_mul
// PURPOSE
//  Pipelined, parametrised successor to the combinational Mitchell/MBM log multiplier.
//  Three register stages: LOD/normalise -> log-add (+error coeff) -> antilog shift.
//  Valid/ready stream on both sides; per-transaction signed/unsigned mode.
//  Sits between operand FIFOs and the accumulator in the approximate-MAC datapath.
// PARAMETERS
//  N      8                   operand width, >=4
//  L      $clog2(N)           leading-one index width
//  ERR_C  (2**(N-1)+6)/12     error coefficient, N-1 fractional bits (N=8 -> 11)
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    block accepts pair this cycle
//  in_signed  in   1    1: operands are two's complement; 0: unsigned
//  a, b       in   N    operands
//  out_valid  out  1    product valid
//  out_ready  in   1    downstream accepts product
//  product    out  2N   approximate product (signedness follows in_signed of the pair)
// BEHAVIOUR
//  - Reset: all stage valid bits 0, out_valid=0, product=0, in_ready=1 after reset release.
//  - Latency 3 cycles accept->out_valid at full throughput; 1 result/cycle sustained.
//  - Transfer on valid&ready. Stage i loads when empty or stage i+1 loads/drains;
//    in_ready = !v1 | adv1 (bubbles collapse). Stalled output holds product stable.
//  - out_valid is never cleared without out_ready; data never dropped or duplicated.
//  - S1: signed mode -> magnitudes |a|,|b| (N bits; -2^(N-1) -> 2^(N-1)), sign=sa^sb.
//    k = index of leading one; x = N-1 bits below it, left-aligned. zero flag if a|b==0.
//  - S2: {cy,f} = x1+x2; char = k1+k2+cy (L+1 bits); mantissa (N+1 bits) = {1,f}.
//  - S3: mag = mantissa << char, rescaled to integer (drop N-1 frac bits, truncate).
//    mag exceeding range saturates: unsigned -> 2^(2N)-1; signed -> 2^(2N-1)-1 magnitude.
//    signed & sign -> product = -mag (2N-bit two's complement).
//  - zero flag -> product = 0 exactly, irrespective of mode and macro.
//  - Exact for both operands powers of two (without macro).
//  - Reset asserted mid-operation: all in-flight results discarded, valids cleared async.
// CONFIGURATION
//  MBM_ERR_COMP_EN defined: S2 mantissa = {1,f} + ERR_C (minimally-biased mode);
//    carry into bit N is kept (mantissa may reach 2.x) and handled by S3 saturation.
//  Undefined: plain Mitchell; ERR_C unused; no adder in S2 mantissa path.
// STRUCTURE
//  Shared package mbm_pkg.vh: localparams for L, frac width N-1, char width L+1,
//    ERR_C default, saturation constants.
//  One sub-module: mbm_lod_norm (combinational LOD + normalising shift, used twice in S1).
//  Stage regs, handshake and S2/S3 arithmetic inline.
// TESTING (N=8)
//  1 unsigned 12*10, no macro -> 112; with MBM_ERR_COMP_EN -> 117; latency 3 cycles.
//  2 unsigned 255*255 -> 65024 no macro; with macro -> 0xFFFF (saturated).
//  3 signed -3*3 -> 0xFFF8 (-8); signed -128*-128 -> 16384; a=0,b=200 -> 0.
//  4 back-to-back 20 pairs, out_ready=1 -> 20 results on consecutive cycles, in order.
//  5 out_ready low 5 cycles mid-stream -> product held, in_ready drops after 3 fills,
//    no loss/duplication vs. reference model after release.
//  6 rst_n pulsed with 2 pairs in flight -> out_valid=0 immediately, no stale output.

Source files
------------

// File: rtl/mbm_pkg.sv
// Shared constants and helpers for the pipelined Mitchell/MBM log multiplier.
// Optional minimally-biased correction: MBM_ERR_COMP_EN.
`timescale 1ns/1ps
package mbm_pkg;

  localparam int MBM_N = 8;

  function automatic int mbm_err_c(input int n);
    return (2 ** (n - 1) + 6) / 12;
  endfunction

  function automatic int mbm_fw(input int n);
    return n - 1;
  endfunction

  localparam int MBM_L = $clog2(MBM_N);
  localparam int MBM_FW = mbm_fw(MBM_N);
  localparam int MBM_CW = MBM_L + 1;
  localparam int MBM_ERR_C = mbm_err_c(MBM_N);

endpackage

// File: rtl/mbm_lod_norm.sv
// Leading-one detector plus normalising shift:
// returns the leading-one index and the bits below it, left-aligned.
`timescale 1ns/1ps
module mbm_lod_norm
  import mbm_pkg::*;
#(
  parameter int N = MBM_N,
  parameter int L = $clog2(N)
) (
  input  logic [N-1:0] mag,
  output logic [L-1:0] k,
  output logic [N-2:0] x
);

  localparam logic [L-1:0] TOP = L'(N - 1);

  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++)
      if (mag[i]) k = L'(i);
  end

  assign x = (N-1)'(mag << (TOP - k));

endmodule

// File: rtl/mbm_pipe_mul.sv
// Three-stage Mitchell log multiplier with valid/ready on both sides.
// Define MBM_ERR_COMP_EN to add the error coefficient to the mantissa.
`timescale 1ns/1ps
module mbm_pipe_mul
  import mbm_pkg::*;
#(
  parameter int N = MBM_N,
  parameter int L = $clog2(N)
`ifdef MBM_ERR_COMP_EN
  , parameter int ERR_C = mbm_err_c(N)
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int FW = mbm_fw(N);
  localparam int CW = L + 1;
  localparam int MW = N + 1;
  localparam int PW = 2 * N;
  localparam logic [PW-1:0] SAT_U = '1;
  localparam logic [PW-1:0] SAT_S = {1'b0, {(PW-1){1'b1}}};

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3 = !v3 | out_ready;
  assign ld2 = !v2 | ld3;
  assign ld1 = !v1 | ld2;
  assign in_ready = ld1;
  assign out_valid = v3;

  logic          sa, sb;
  logic [N-1:0]  ma, mb;
  logic [L-1:0]  ka, kb;
  logic [FW-1:0] xa, xb;

  assign sa = in_signed & a[N-1];
  assign sb = in_signed & b[N-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  mbm_lod_norm #(.N(N), .L(L)) u_lod_a (
    .mag(ma), .k(ka), .x(xa)
  );

  mbm_lod_norm #(.N(N), .L(L)) u_lod_b (
    .mag(mb), .k(kb), .x(xb)
  );

  logic          s1_sgn, s1_neg, s1_zero;
  logic [L-1:0]  s1_ka, s1_kb;
  logic [FW-1:0] s1_xa, s1_xb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_neg  <= 1'b0;
      s1_zero <= 1'b0;
      s1_ka   <= '0;
      s1_kb   <= '0;
      s1_xa   <= '0;
      s1_xb   <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_sgn  <= in_signed;
        s1_neg  <= sa ^ sb;
        s1_zero <= (a == '0) | (b == '0);
        s1_ka   <= ka;
        s1_kb   <= kb;
        s1_xa   <= xa;
        s1_xb   <= xb;
      end
    end
  end

  logic [FW:0]   fsum;
  logic [CW-1:0] chr;
  logic [MW-1:0] mant;

  assign fsum = {1'b0, s1_xa} + {1'b0, s1_xb};
  assign chr  = CW'(s1_ka) + CW'(s1_kb) + CW'(fsum[FW]);
`ifdef MBM_ERR_COMP_EN
  // Carry into bit N is kept; an oversized result is caught by S3 saturation.
  assign mant = {2'b01, fsum[FW-1:0]} + MW'(ERR_C);
`else
  assign mant = {2'b01, fsum[FW-1:0]};
`endif

  logic          s2_sgn, s2_neg, s2_zero;
  logic [CW-1:0] s2_chr;
  logic [MW-1:0] s2_mant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_sgn  <= 1'b0;
      s2_neg  <= 1'b0;
      s2_zero <= 1'b0;
      s2_chr  <= '0;
      s2_mant <= '0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_sgn  <= s1_sgn;
        s2_neg  <= s1_neg;
        s2_zero <= s1_zero;
        s2_chr  <= chr;
        s2_mant <= mant;
      end
    end
  end

  logic [PW:0]   mag;
  logic [PW-1:0] mag_s;
  logic [PW-1:0] prod;

  // Antilog: shift by the characteristic, then drop the FW fraction bits.
  assign mag = (PW+1)'(({{(PW-1){1'b0}}, s2_mant} << s2_chr) >> FW);

  assign mag_s = s2_sgn ? ((|mag[PW:PW-1]) ? SAT_S : mag[PW-1:0])
                        : (mag[PW] ? SAT_U : mag[PW-1:0]);

  assign prod = s2_zero ? '0
              : (s2_sgn & s2_neg) ? -mag_s : mag_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      product <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) product <= prod;
    end
  end

endmodule

// File: tb/tb_mbm_pipe_mul.sv
// Scoreboard bench for mbm_pipe_mul (N=8), with a log-domain reference model.
// Expectations follow MBM_ERR_COMP_EN when it is defined.
`timescale 1ns/1ps
module tb_mbm_pipe_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;

  always #5 clk = ~clk;

  mbm_pipe_mul #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] expq[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h want none", nm, act);
  endtask

  // Mitchell in the log domain: log2(m) ~ k + frac, antilog ~ 2^c * (1+f).
  function automatic logic [15:0] model(input logic [7:0] x, y,
                                        input logic sg);
    int ma, mb, ka, kb, lg, mant;
    longint m;
    bit neg;
    ma = (sg && x[7]) ? 256 - int'(x) : int'(x);
    mb = (sg && y[7]) ? 256 - int'(y) : int'(y);
    neg = sg && (x[7] ^ y[7]);
    if (ma == 0 || mb == 0) return 16'h0;
    ka = 0;
    while ((ma >> (ka + 1)) != 0) ka++;
    kb = 0;
    while ((mb >> (kb + 1)) != 0) kb++;
    lg = (ka + kb) * 128 + ((ma - (1 << ka)) << (7 - ka))
       + ((mb - (1 << kb)) << (7 - kb));
    mant = 128 + lg % 128;
`ifdef MBM_ERR_COMP_EN
    mant += (128 + 6) / 12;
`endif
    m = (longint'(mant) << (lg / 128)) >> 7;
    if (!sg) return (m > 65535) ? 16'hFFFF : 16'(m);
    if (m > 32767) m = 32767;
    return neg ? 16'(-m) : 16'(m);
  endfunction

  task automatic send_exp(input logic [7:0] x, y, input logic sg,
                          input logic [15:0] e);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    in_signed = sg;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(e);
        return;
      end
    end
    fail_now("send_timeout", {24'h0, x});
  endtask

  task automatic send(input logic [7:0] x, y, input logic sg);
    send_exp(x, y, sg, model(x, y, sg));
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && expq.size() != 0; i++)
      @(negedge clk);
    @(negedge clk);
    check("drain_left", expq.size(), 0);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] edges [4];
    edges = '{8'h00, 8'h80, 8'hFF, 8'h01};
    if ($urandom_range(5) == 0) return edges[$urandom_range(3)];
    return 8'($urandom);
  endfunction

  logic        hold_v = 1'b0;
  logic [15:0] hold_p = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", product, hold_p);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) fail_now("unexpected_out", product);
        else check("product", product, expq.pop_front());
      end
      hold_v = out_valid && !out_ready;
      hold_p = product;
    end
  end

  int  lat;
  int  run;
  bit  done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // latency of a lone transaction
`ifdef MBM_ERR_COMP_EN
    send_exp(8'd12, 8'd10, 1'b0, 16'd117);
`else
    send_exp(8'd12, 8'd10, 1'b0, 16'd112);
`endif
    fork
      idle();
      begin
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          if (out_valid) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("latency", lat, 3);
    drain();

    // directed corner values
`ifdef MBM_ERR_COMP_EN
    send_exp(8'd255, 8'd255, 1'b0, 16'hFFFF);
    send_exp(8'h80, 8'h80, 1'b1, 16'd17792);
    send_exp(8'd64, 8'd32, 1'b0, 16'd2224);
`else
    send_exp(8'd255, 8'd255, 1'b0, 16'd65024);
    send_exp(8'h80, 8'h80, 1'b1, 16'd16384);
    send_exp(8'd64, 8'd32, 1'b0, 16'd2048);
`endif
    send_exp(8'hFD, 8'd3, 1'b1, 16'hFFF8);
    send_exp(8'd0, 8'd200, 1'b0, 16'd0);
    send_exp(8'd200, 8'd0, 1'b1, 16'd0);
    send_exp(8'h80, 8'h7F, 1'b1, model(8'h80, 8'h7F, 1'b1));
    idle();
    drain();

    // 20 back-to-back pairs must emerge on consecutive cycles
    fork
      begin
        for (int i = 0; i < 20; i++) send(pick(), pick(), 1'($urandom));
        idle();
      end
      begin
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        run = 0;
        while (out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
      end
    join
    check("b2b_run", run, 20);
    drain();

    // 5-cycle output stall with a continuously offered input stream
    fork
      begin
        for (int i = 0; i < 6; i++) send(pick(), pick(), 1'($urandom));
        idle();
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with two results in flight
    send(8'd77, 8'd91, 1'b0);
    send(8'd5, 8'd250, 1'b0);
    idle();
    @(posedge clk);
    #2 check("pre_rst_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_product", product, 0);
    check("mid_rst_in_ready", in_ready, 1);
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_valid", out_valid, 0);

    // randomized traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(pick(), pick(), 1'($urandom));
          if ($urandom_range(3) == 0) idle();
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
